// File: rtl/note_sequencer.sv
// note_sequencer: SRAM-fed multi-channel square-wave tune player.
// Define MIX_PWM_EN for PWM mixing of channels; default is OR mixing.
module note_sequencer #(
   parameter int          CLK_HZ          = 50000000,
   parameter int          NUM_CH          = 4,
   parameter int          SRAM_LAT        = 2,
   parameter int          PITCH_UNIT_LOG2 = 6,
   parameter int          DEFAULT_BPM     = 96,
   parameter logic [17:0] START_ADDR      = 18'd0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic        STOP,
   output logic [17:0] SRAM_A,
   input  logic [15:0] SRAM_D,
   output logic        SRAM_WE,
   output logic        SRAM_CE,
   output logic        SRAM_OE,
   output logic        SRAM_LB,
   output logic        SRAM_UB,
   output logic        SPEAKER,
   output logic        PLAYING,
   output logic [9:0]  LED_R,
   output logic [7:0]  LED_G
);

   localparam logic [31:0] DIVIDEND = 32'(64'(CLK_HZ) * 64'd15);
   localparam logic [31:0] CYC_DEF  = DIVIDEND / 32'(DEFAULT_BPM);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_DIV
   } state_t;

   state_t       r_state, w_next;
   logic [17:0]  r_pc, r_addr, w_pc_exec, w_pc_fetch;
   logic [2:0]   r_sel, r_fcnt;
   logic [11:0]  r_bpm, r_rem, w_bpm_cl;
   logic [31:0]  r_cyc16, r_wait, r_quo, w_quo_n;
   logic [4:0]   r_dcnt;
   logic [15:0]  r_ins;
   logic [12:0]  w_rsh, w_rem_n;
   logic         w_ge;
   logic [17:0]  r_hp  [NUM_CH];
   logic [17:0]  r_cnt [NUM_CH];
   logic [NUM_CH-1:0] r_wave;
   logic [17:0]  w_hp_new;
   logic         r_spk;
   logic [7:0]   w_ledg;
   logic         w_note, w_end, w_setbpm, w_selch, w_jump;
   logic [2:0]   w_op, w_dur;
   logic         w_load, w_clr, w_run;

   assign w_note   = r_ins[15];
   assign w_op     = r_ins[14:12];
   assign w_dur    = r_ins[14:12];
   assign w_end    = !w_note && (w_op == 3'd0);
   assign w_setbpm = !w_note && (w_op == 3'd1);
   assign w_selch  = !w_note && (w_op == 3'd2);
   assign w_jump   = !w_note && (w_op == 3'd3);
   assign w_bpm_cl = (r_ins[11:0] < 12'd20) ? 12'd20 : r_ins[11:0];
   assign w_hp_new = 18'(r_ins[11:0]) << PITCH_UNIT_LOG2;

   assign w_pc_exec = w_jump ? {6'd0, r_ins[11:0]} : r_pc + 18'd1;

   assign w_rsh   = {r_rem, r_quo[31]};
   assign w_ge    = w_rsh >= {1'b0, r_bpm};
   assign w_rem_n = w_ge ? w_rsh - {1'b0, r_bpm} : w_rsh;
   assign w_quo_n = {r_quo[30:0], w_ge};

   assign w_run  = (r_state != S_IDLE);
   assign w_clr  = w_run && (w_next == S_IDLE);
   assign w_load = (r_state == S_EXEC) && w_note && !STOP;

   // state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state decode; STOP overrides everything
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (START) w_next = S_FETCH;
         S_FETCH: if (r_fcnt == 3'(SRAM_LAT)) w_next = S_EXEC;
         S_EXEC: begin
            if (w_note)
               w_next = (w_dur == 3'd0) ? S_FETCH : S_WAIT;
            else if (w_end)
               w_next = S_IDLE;
            else if (w_setbpm)
               w_next = S_DIV;
            else
               w_next = S_FETCH;
         end
         S_WAIT:  if (r_wait <= 32'd1) w_next = S_FETCH;
         S_DIV:   if (r_dcnt == 5'd31) w_next = S_FETCH;
         default: w_next = S_IDLE;
      endcase
      if (STOP) w_next = S_IDLE;
   end

   // address presented on entry to FETCH
   always_comb begin
      w_pc_fetch = r_pc;
      if (r_state == S_IDLE) w_pc_fetch = START_ADDR;
      if (r_state == S_EXEC) w_pc_fetch = w_pc_exec;
   end

   // sequencer datapath: pc, fetch, tempo, wait and divider
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pc    <= START_ADDR;
         r_addr  <= 18'd0;
         r_sel   <= 3'd0;
         r_bpm   <= 12'(DEFAULT_BPM);
         r_cyc16 <= CYC_DEF;
         r_fcnt  <= 3'd0;
         r_ins   <= 16'd0;
         r_wait  <= 32'd0;
         r_quo   <= 32'd0;
         r_rem   <= 12'd0;
         r_dcnt  <= 5'd0;
      end else begin
         if (r_state == S_FETCH && w_next == S_FETCH)
            r_fcnt <= r_fcnt + 3'd1;
         else
            r_fcnt <= 3'd0;
         if (w_next == S_FETCH && r_state != S_FETCH)
            r_addr <= w_pc_fetch;
         unique case (r_state)
            S_IDLE: begin
               if (START && !STOP) begin
                  r_pc    <= START_ADDR;
                  r_sel   <= 3'd0;
                  r_bpm   <= 12'(DEFAULT_BPM);
                  r_cyc16 <= CYC_DEF;
               end
            end
            S_FETCH: begin
               if (r_fcnt == 3'(SRAM_LAT)) r_ins <= SRAM_D;
            end
            S_EXEC: begin
               r_pc <= w_pc_exec;
               if (w_note && w_dur != 3'd0)
                  r_wait <= r_cyc16 << (w_dur - 3'd1);
               if (w_setbpm) begin
                  r_bpm  <= w_bpm_cl;
                  r_quo  <= DIVIDEND;
                  r_rem  <= 12'd0;
                  r_dcnt <= 5'd0;
               end
               if (w_selch && ({1'b0, r_ins[2:0]} < 4'(NUM_CH)))
                  r_sel <= r_ins[2:0];
            end
            S_WAIT: r_wait <= r_wait - 32'd1;
            S_DIV: begin
               r_dcnt <= r_dcnt + 5'd1;
               r_quo  <= w_quo_n;
               r_rem  <= w_rem_n[11:0];
               if (r_dcnt == 5'd31) r_cyc16 <= w_quo_n;
            end
            default: ;
         endcase
      end
   end

   // tone generators: reload on NOTE, silence on stop/end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_hp[i]  <= 18'd0;
            r_cnt[i] <= 18'd0;
         end
         r_wave <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_clr) begin
               r_hp[i]   <= 18'd0;
               r_cnt[i]  <= 18'd0;
               r_wave[i] <= 1'b0;
            end else if (w_load && r_sel == 3'(i)) begin
               r_hp[i]   <= w_hp_new;
               r_cnt[i]  <= 18'd0;
               r_wave[i] <= 1'b0;
            end else if (r_hp[i] == 18'd0) begin
               r_cnt[i]  <= 18'd0;
               r_wave[i] <= 1'b0;
            end else if (w_run) begin
               if (r_cnt[i] == r_hp[i] - 18'd1) begin
                  r_cnt[i]  <= 18'd0;
                  r_wave[i] <= ~r_wave[i];
               end else begin
                  r_cnt[i] <= r_cnt[i] + 18'd1;
               end
            end
         end
      end
   end

   // channel activity lamps
   always_comb begin
      w_ledg = 8'd0;
      for (int i = 0; i < NUM_CH; i++) w_ledg[i] = |r_hp[i];
   end

`ifdef MIX_PWM_EN
   logic [7:0]  r_ramp;
   logic [3:0]  w_k;
   logic [11:0] w_thr;

   // count of channels currently high
   always_comb begin
      w_k = 4'd0;
      for (int i = 0; i < NUM_CH; i++) w_k = w_k + 4'(r_wave[i]);
   end

   assign w_thr = (12'(w_k) << 8) / 12'(NUM_CH);

   // PWM mixer: duty proportional to active channel count
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ramp <= 8'd0;
         r_spk  <= 1'b0;
      end else begin
         r_ramp <= r_ramp + 8'd1;
         r_spk  <= ({4'd0, r_ramp} < w_thr);
      end
   end
`else
   // OR mixer
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_spk <= 1'b0;
      else     r_spk <= |r_wave;
   end
`endif

   assign SRAM_A  = r_addr;
   assign SRAM_WE = 1'b1;
   assign SRAM_CE = 1'b0;
   assign SRAM_OE = 1'b0;
   assign SRAM_LB = 1'b0;
   assign SRAM_UB = 1'b0;
   assign SPEAKER = r_spk;
   assign PLAYING = w_run;
   assign LED_R   = r_pc[9:0];
   assign LED_G   = w_ledg;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Multi-channel tune player that fetches 16-bit instructions from external async SRAM, decodes notes and settings, and drives NUM_CH square-wave tone generators mixed onto SPEAKER.
- Successor to the single-note fetch/play loop: adds programmable tempo with a runtime divider, note durations, chords, jumps, end-of-program, start/stop control and parametrised channel count and SRAM latency.
- Sits between the board SRAM pins and the speaker/LED pins at top level.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- NUM_CH, 4, tone channels (1..8).
- SRAM_LAT, 2, cycles from SRAM_A change to valid SRAM_D (1..7).
- PITCH_UNIT_LOG2, 6, half-period = P << PITCH_UNIT_LOG2 clocks.
- DEFAULT_BPM, 96, tempo after reset/START (20..4095).
- START_ADDR, 0, 18-bit first instruction address.

Ports:
- CLK  in  1  clock, all logic on posedge.
- RST  in  1  reset; asynchronous and active-high.
- START  in  1  one-cycle pulse, begins playback from START_ADDR.
- STOP  in  1  one-cycle pulse, aborts playback.
- SRAM_A  out  18  instruction address.
- SRAM_D  in  16  instruction data.
- SRAM_WE/SRAM_CE/SRAM_OE/SRAM_LB/SRAM_UB  out  1 each  constant 1/0/0/0/0 (read-only).
- SPEAKER  out  1  mixed audio.
- PLAYING  out  1  high while the sequencer is running.
- LED_R  out  10  pc[9:0].
- LED_G  out  8  bit i = channel i has nonzero pitch (bits >= NUM_CH are 0).

Behaviour:
- Instruction: bit15=1 NOTE: [14:12] dur code d, [11:0] pitch P (P=0 is rest). Length = 0 sixteenths if d=0 (no wait, chord building), else 2^(d-1) sixteenths (1..64). Applies to the selected channel.
- bit15=0 SETTING, [14:12] opcode: 000 END; 001 SET_BPM [11:0] (values <20 clamp to 20); 010 SEL_CH [2:0] (index >= NUM_CH is a no-op); 011 JUMP [11:0] absolute (upper pc bits zeroed); others NOP.
- FSM: IDLE -> FETCH -> EXEC -> {FETCH | WAIT | DIV | IDLE}.
- IDLE: PLAYING=0, all channels silent. START: pc<=START_ADDR, sel_ch<=0, bpm<=DEFAULT_BPM, cyc16<=CLK_HZ*15/DEFAULT_BPM (elaboration constant), go to FETCH.
- FETCH: SRAM_A<=pc on entry; stays SRAM_LAT+1 cycles; ins<=SRAM_D on the last cycle.
- EXEC (1 cycle): pc<=pc+1 (wraps at 2^18) except on JUMP. A NOTE loads the channel; d=0 goes to FETCH, else wait_cnt<=len*cyc16 and goes to WAIT. SET_BPM goes to DIV. END goes to IDLE. Others go to FETCH.
- WAIT: wait_cnt decrements; at 1 goes to FETCH, so a note spans exactly len*cyc16 cycles from EXEC to next FETCH entry.
- DIV: 32-bit restoring divider computes cyc16 = CLK_HZ*15/bpm at 1 bit/cycle, 32 cycles, then goes to FETCH. Truncating. wait_cnt is 32-bit; the clamp keeps 64*cyc16 < 2^32.
- Channel i: hp = P<<PITCH_UNIT_LOG2 (18 bits). Loading a new pitch sets cnt<=0 and wave<=0. If hp=0, wave=0. Else cnt counts up; at hp-1, cnt<=0 and wave toggles. Generators run in FETCH/EXEC/WAIT/DIV and keep sounding across notes until reloaded.
- STOP (any non-IDLE state) or END: next state IDLE, all hp<=0, waves 0 next cycle. START while not IDLE is ignored. START and STOP together: STOP wins.
- RST (async, any time): state IDLE, pc=START_ADDR, SRAM_A=0, all channels 0, SPEAKER=0, PLAYING=0, LED_R=START_ADDR[9:0], LED_G=0, bpm=DEFAULT_BPM.
- Mixer default: SPEAKER = OR of channel waves, registered (1-cycle latency).

Optional Feature:
- MIX_PWM_EN defined: SPEAKER is a PWM of the count k of high waves. A free-running 8-bit ramp r (r+=1 each clock) drives SPEAKER = (r < k*256/NUM_CH), registered.
- MIX_PWM_EN undefined: OR mixing, no ramp logic.

Test Plan:
- Reset: assert RST mid-WAIT -> SPEAKER=0, PLAYING=0, LED_G=0 within the same cycle. After release, no activity until START.
- CLK_HZ=16000, bpm 60 (cyc16=4000). Program [NOTE d=1 P=5, END] -> wave toggles every 320 cycles for 4000 cycles, then PLAYING falls and SPEAKER=0.
- Chord: [SEL_CH 0, NOTE d=0 P=5, SEL_CH 1, NOTE d=3 P=7, END] -> LED_G=8'b00000011 for 16000 cycles. Ch1 half-period 448.
- Tempo: SET_BPM 120 -> cyc16=2000 after 32 DIV cycles, NOTE d=1 lasts 2000. SET_BPM 5 -> clamped, cyc16=12000.
- Loop/stop: [NOTE d=1 P=1, JUMP 0] -> SRAM_A repeats 0,1,0,1 indefinitely. STOP pulse -> IDLE next cycle, START restarts at 0.
- SRAM_LAT=3: SRAM_D is driven only on the 4th FETCH cycle -> correct instruction captured. Changed data one cycle earlier is ignored.
